lsu_splice_unit: RTL and testbench

// - Parametrised load/store splicer between the core's memory stage and an XLEN-wide, naturally

---
 rtl/lsu_splice_unit.sv | 216 +++++++++++++++++++++
 tb/tb_lsu_splice_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_splice_unit.sv
// Load/store splicer between the core memory stage and an XLEN-wide, naturally aligned data port.
// Handles B/H/W/D accesses, sign/zero extension, byte enables and optional two-beat line crossing.
`timescale 1ns/1ps
module lsu_splice_unit #(
  parameter int XLEN               = 64,
  parameter int ADDR_W             = 64,
  parameter int SUPPORT_MISALIGNED = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                rsp_valid,
  output logic [XLEN-1:0]     rsp_rdata,
  output logic                rsp_err
);
  localparam int LB    = XLEN / 8;
  localparam int OFF_W = $clog2(LB);

  typedef enum logic [2:0] {IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP} state_t;

  state_t              state_reg;
  logic                we_reg;
  logic                unsigned_reg;
  logic                split_reg;
  logic [1:0]          size_reg;
  logic [OFF_W-1:0]    off_reg;
  logic [ADDR_W-1:0]   line_reg;
  logic [XLEN-1:0]     wdata_reg;
  logic [XLEN-1:0]     line0_reg;

  // Lane placement works off the live request in IDLE and the latched one afterwards.
  logic [1:0]          cur_size;
  logic [OFF_W-1:0]    cur_off;
  logic [XLEN-1:0]     cur_wdata;
  logic [4:0]          cur_nbytes;
  logic [LB-1:0]       cur_keep;
  logic [2*LB-1:0]     be_full;
  logic [2*XLEN-1:0]   wd_full;
  logic                need_split;
  logic [ADDR_W-1:0]   req_line;

  assign cur_size   = (state_reg == IDLE) ? req_size : size_reg;
  assign cur_off    = (state_reg == IDLE) ? req_addr[OFF_W-1:0] : off_reg;
  assign cur_wdata  = (state_reg == IDLE) ? req_wdata : wdata_reg;
  assign cur_nbytes = 5'd1 << cur_size;
  assign cur_keep   = ~({LB{1'b1}} << cur_nbytes);
  assign be_full    = {{LB{1'b0}}, cur_keep} << cur_off;
  assign wd_full    = {{XLEN{1'b0}}, cur_wdata} << {cur_off, 3'b000};
  assign need_split = |be_full[2*LB-1:LB];
  assign req_line   = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  // Load assembly: the two beats form one 2*XLEN window shifted down by the byte offset.
  logic [XLEN-1:0]     asm_lo;
  logic [XLEN-1:0]     asm_hi;
  logic [XLEN-1:0]     ld_raw;
  logic [XLEN-1:0]     ld_ext;
  logic [LB-1:0]       ld_keep;
  logic                ld_sign;
  logic                ld_fill;

  assign asm_lo  = (state_reg == WAIT1) ? line0_reg : mem_rdata;
  assign asm_hi  = (state_reg == WAIT1) ? mem_rdata : '0;
  assign ld_raw  = XLEN'({asm_hi, asm_lo} >> {off_reg, 3'b000});
  assign ld_keep = ~({LB{1'b1}} << (5'd1 << size_reg));

  always_comb begin
    ld_sign = ld_raw[XLEN-1];
    case (size_reg)
      2'd0:    ld_sign = ld_raw[7];
      2'd1:    ld_sign = ld_raw[15];
      2'd2:    ld_sign = ld_raw[31];
      default: ld_sign = ld_raw[XLEN-1];
    endcase
  end

  assign ld_fill = ld_sign & ~unsigned_reg;

  generate
    for (genvar gi = 0; gi < LB; gi++) begin : g_ext
      assign ld_ext[8*gi +: 8] = ld_keep[gi] ? ld_raw[8*gi +: 8] : {8{ld_fill}};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      req_ready    <= 1'b1;
      mem_valid    <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      we_reg       <= 1'b0;
      unsigned_reg <= 1'b0;
      split_reg    <= 1'b0;
      size_reg     <= '0;
      off_reg      <= '0;
      line_reg     <= '0;
      wdata_reg    <= '0;
      line0_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            req_ready    <= 1'b0;
            we_reg       <= req_we;
            unsigned_reg <= req_unsigned;
            split_reg    <= need_split;
            size_reg     <= req_size;
            off_reg      <= req_addr[OFF_W-1:0];
            line_reg     <= req_line;
            wdata_reg    <= req_wdata;
            if (need_split && SUPPORT_MISALIGNED == 0) begin
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              state_reg <= BEAT0;
              mem_valid <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= req_line;
              mem_be    <= be_full[LB-1:0];
              mem_wdata <= req_we ? wd_full[XLEN-1:0] : '0;
            end
          end
        end
        BEAT0: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (!we_reg) begin
              state_reg <= WAIT0;
            end else if (split_reg) begin
              state_reg <= BEAT1;
              mem_valid <= 1'b1;
              mem_addr  <= line_reg + ADDR_W'(LB);
              mem_be    <= be_full[2*LB-1:LB];
              mem_wdata <= wd_full[2*XLEN-1:XLEN];
            end else begin
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
            end
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            if (split_reg) begin
              line0_reg <= mem_rdata;
              state_reg <= BEAT1;
              mem_valid <= 1'b1;
              mem_addr  <= line_reg + ADDR_W'(LB);
              mem_be    <= be_full[2*LB-1:LB];
              mem_wdata <= '0;
            end else begin
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= ld_ext;
            end
          end
        end
        BEAT1: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            if (we_reg) begin
              state_reg <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= '0;
            end else begin
              state_reg <= WAIT1;
            end
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            state_reg <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= ld_ext;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          req_ready <= 1'b1;
          mem_valid <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_splice_unit.sv
// Randomized bench for lsu_splice_unit against a byte-level load/store reference model.
// A second instance with misaligned support disabled covers the error path.
`timescale 1ns/1ps
module tb_lsu_splice_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, nm_req_valid;
  logic        req_ready, nm_req_ready;
  logic        req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        mem_valid, mem_ready, mem_we, mem_rvalid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_be;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        nm_mem_valid, nm_mem_we, nm_rsp_valid, nm_rsp_err;
  logic [63:0] nm_mem_addr, nm_mem_wdata, nm_rsp_rdata;
  logic [7:0]  nm_mem_be;

  always #5 clk = ~clk;

  lsu_splice_unit #(.XLEN(64), .ADDR_W(64), .SUPPORT_MISALIGNED(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  lsu_splice_unit #(.XLEN(64), .ADDR_W(64), .SUPPORT_MISALIGNED(0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .req_valid(nm_req_valid), .req_ready(nm_req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_valid(nm_mem_valid), .mem_ready(mem_ready), .mem_we(nm_mem_we), .mem_addr(nm_mem_addr),
    .mem_be(nm_mem_be), .mem_wdata(nm_mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(nm_rsp_valid), .rsp_rdata(nm_rsp_rdata), .rsp_err(nm_rsp_err));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  typedef struct { logic we; logic [63:0] addr; logic [7:0] be; logic [63:0] wdata; } beat_t;

  beat_t       beats[$];
  beat_t       stall_q[$];
  beat_t       last_beat;
  logic        last_hs;
  logic [7:0]  dev_mem [logic [63:0]];
  logic [7:0]  ref_mem [logic [63:0]];
  logic        fast, nm_saw_valid, rvalid_seen;
  int          stall_n, rdelay_force, rd_wait;
  logic [63:0] rd_addr;
  logic [63:0] g_rdata;

  function automatic logic [7:0] fill_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] dev_rd(input logic [63:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : fill_byte(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [63:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fill_byte(a);
  endfunction

  function automatic logic [63:0] dev_line(input logic [63:0] la);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = dev_rd(la + 64'(i));
    return v;
  endfunction

  // Memory device: stalls, byte-enable writes and in-order read returns.
  initial begin
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    rd_wait = 0; rd_addr = '0; last_hs = 1'b0; rvalid_seen = 1'b0; nm_saw_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (nm_mem_valid) nm_saw_valid = 1'b1;
      mem_rvalid = 1'b0;
      mem_rdata  = {$urandom, $urandom};
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin mem_rvalid = 1'b1; mem_rdata = dev_line(rd_addr); rvalid_seen = 1'b1; end
      end
      if (last_hs) begin
        beats.push_back(last_beat);
        if (last_beat.we) begin
          for (int i = 0; i < 8; i++)
            if (last_beat.be[i]) dev_mem[last_beat.addr + 64'(i)] = last_beat.wdata[8*i +: 8];
        end else begin
          rd_addr = last_beat.addr;
          rd_wait = (rdelay_force >= 0) ? rdelay_force : (fast ? 0 : int'($urandom_range(0, 2)));
          if (rd_wait == 0) begin mem_rvalid = 1'b1; mem_rdata = dev_line(rd_addr); rvalid_seen = 1'b1; end
        end
      end
      if (mem_valid && stall_n > 0) begin
        stall_q.push_back('{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata});
        stall_n--;
        mem_ready = 1'b0;
      end else begin
        mem_ready = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      last_hs   = mem_valid && mem_ready;
      last_beat = '{we: mem_we, addr: mem_addr, be: mem_be, wdata: mem_wdata};
    end
  end

  task automatic run_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wdata, input int extra);
    int          off, n, nb, lat;
    logic [7:0]  be0, be1;
    logic [63:0] wd0, wd1, exp_val, line0, a;
    off = int'(addr[2:0]);
    n = 1 << size;
    line0 = addr & ~64'h7;
    be0 = '0; be1 = '0;
    for (int k = 0; k < n; k++) begin
      a = addr + 64'(k);
      if ((a & ~64'h7) == line0) be0[a[2:0]] = 1'b1;
      else be1[a[2:0]] = 1'b1;
    end
    nb  = (be1 != 0) ? 2 : 1;
    wd0 = wdata << (8 * off);
    wd1 = wdata >> (8 * (8 - off));
    exp_val = '0;
    if (!we) begin
      for (int k = 0; k < n; k++) exp_val[8*k +: 8] = ref_rd(addr + 64'(k));
      if (!uns && n < 8 && exp_val[8*n-1]) exp_val = exp_val | (~64'h0 << (8 * n));
    end
    @(negedge clk);
    lat = 0;
    while (!req_ready && lat < 50) begin @(negedge clk); lat++; end
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    beats.delete();
    @(negedge clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom_range(0, 3)); req_unsigned = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    lat = 1;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    check("rsp_valid_seen", rsp_valid, 1);
    check("rsp_rdata", rsp_rdata, exp_val);
    check("rsp_err", rsp_err, 0);
    if (fast) check("latency", lat, (we ? 1 + nb : 1 + 2 * nb) + extra);
    g_rdata = rsp_rdata;
    @(negedge clk);
    check("rsp_pulse_width", rsp_valid, 0);
    check("req_ready_after", req_ready, 1);
    check("rsp_rdata_hold", rsp_rdata, exp_val);
    check("beat_count", beats.size(), nb);
    for (int i = 0; i < beats.size() && i < 2; i++) begin
      check("beat_addr", beats[i].addr, (i == 0) ? line0 : line0 + 64'd8);
      check("beat_be", beats[i].be, (i == 0) ? be0 : be1);
      check("beat_we", beats[i].we, we);
      if (we) check("beat_wdata", beats[i].wdata, (i == 0) ? wd0 : wd1);
    end
    if (we) for (int k = 0; k < n; k++) ref_mem[addr + 64'(k)] = wdata[8*k +: 8];
    $display("op %s size=%0d uns=%0d addr=0x%h wdata=0x%h -> rdata=0x%h beats=%0d lat=%0d",
             we ? "ST" : "LD", size, uns, addr, wdata, g_rdata, beats.size(), lat);
  endtask

  initial begin
    logic [63:0] preload;
    logic [63:0] sd_data;
    logic        seen;
    int          n;
    req_valid = 1'b0; nm_req_valid = 1'b0; req_we = 1'b0; req_size = '0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; fast = 1'b1; stall_n = 0; rdelay_force = -1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_mem_valid", mem_valid, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst_n = 1'b1;
    @(negedge clk);

    preload = 64'h1122334488776655;
    for (int i = 0; i < 8; i++) begin
      dev_mem[64'h1000 + 64'(i)] = preload[8*i +: 8];
      ref_mem[64'h1000 + 64'(i)] = preload[8*i +: 8];
    end
    dev_mem[64'h1008] = 8'hAA; ref_mem[64'h1008] = 8'hAA;
    dev_mem[64'h1009] = 8'hBB; ref_mem[64'h1009] = 8'hBB;

    run_op(1'b0, 2'd0, 1'b0, 64'h1003, '0, 0);
    check("t1_lb", g_rdata, 64'hFFFF_FFFF_FFFF_FF88);
    if (beats.size() == 1) check("t1_lb_be", beats[0].be, 8'h08);
    run_op(1'b0, 2'd0, 1'b1, 64'h1003, '0, 0);
    check("t1_lbu", g_rdata, 64'h88);

    run_op(1'b0, 2'd2, 1'b0, 64'h1006, '0, 0);
    check("t3_lw", g_rdata, 64'hFFFF_FFFF_BBAA_1122);
    if (beats.size() == 2) begin
      check("t3_b0_addr", beats[0].addr, 64'h1000);
      check("t3_b0_be", beats[0].be, 8'hC0);
      check("t3_b1_addr", beats[1].addr, 64'h1008);
      check("t3_b1_be", beats[1].be, 8'h03);
    end
    run_op(1'b0, 2'd2, 1'b1, 64'h1006, '0, 0);
    check("t3_lwu", g_rdata, 64'h0000_0000_BBAA_1122);

    run_op(1'b1, 2'd1, 1'b0, 64'h2006, 64'hABCD, 0);
    check("t2_sh_rdata", g_rdata, 0);
    if (beats.size() == 1) begin
      check("t2_sh_addr", beats[0].addr, 64'h2000);
      check("t2_sh_be", beats[0].be, 8'hC0);
      check("t2_sh_lane", beats[0].wdata[63:48], 16'hABCD);
    end

    // Misaligned doubleword on the instance without split support.
    @(negedge clk);
    nm_saw_valid = 1'b0;
    req_we = 1'b0; req_size = 2'd3; req_unsigned = 1'b0; req_addr = 64'h1004;
    check("t4_nm_ready", nm_req_ready, 1);
    nm_req_valid = 1'b1;
    @(negedge clk);
    nm_req_valid = 1'b0;
    n = 1;
    while (!nm_rsp_valid && n < 50) begin @(negedge clk); n++; end
    check("t4_latency", n, 1);
    check("t4_rsp_err", nm_rsp_err, 1);
    check("t4_rsp_rdata", nm_rsp_rdata, 0);
    @(negedge clk);
    check("t4_pulse_width", nm_rsp_valid, 0);
    check("t4_ready_after", nm_req_ready, 1);
    check("t4_no_mem_valid", nm_saw_valid, 0);
    $display("op LD size=3 addr=0x1004 on no-misaligned instance -> err=%0d", nm_rsp_err);

    sd_data = {$urandom, $urandom};
    stall_q.delete();
    stall_n = 5;
    run_op(1'b1, 2'd3, 1'b0, 64'h3000, sd_data, 5);
    check("t5_stall_samples", stall_q.size(), 5);
    foreach (stall_q[i]) begin
      check("t5_stall_addr", stall_q[i].addr, 64'h3000);
      check("t5_stall_be", stall_q[i].be, 8'hFF);
      check("t5_stall_wdata", stall_q[i].wdata, sd_data);
    end

    for (int t = 0; t < 160; t++) begin
      fast = (t < 60);
      run_op(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             64'h1000 + 64'($urandom_range(0, 63)), {$urandom, $urandom}, 0);
    end

    // Reset during the second wait of a split load; the late read return must be ignored.
    fast = 1'b1;
    rdelay_force = 6;
    @(negedge clk);
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 64'h1006; req_valid = 1'b1;
    beats.delete();
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (beats.size() < 2 && n < 100) begin @(negedge clk); n++; end
    check("t6_beats_before_reset", beats.size(), 2);
    rst_n = 1'b0;
    #1;
    check("t6_mem_valid", mem_valid, 0);
    check("t6_req_ready", req_ready, 1);
    check("t6_rsp_valid", rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rvalid_seen = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    check("t6_no_rsp_after_reset", seen, 0);
    check("t6_late_rvalid_sent", rvalid_seen, 1);
    $display("op reset during split load wait -> rsp_seen=%0d", seen);
    rdelay_force = -1;
    run_op(1'b0, 2'd1, 1'b1, 64'h1007, '0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
